l1d_inorder_issue_buffer: RTL and testbench
===========================================

# l1d_inorder_issue_buffer

Circular in-order request buffer that sits directly upstream of the L1D in-order router. It accepts up to ENQ_WIDTH requests per cycle, holds them in age order, and presents the oldest DEQ_WIDTH entries (valid plus per-destination enables) as the router's source vector. The router's per-source success vector is fed back to retire the successful oldest prefix in the same cycle.

## Interface
- ENTRY_COUNT, 8, buffer depth; power of two, ≥ DEQ_WIDTH and ≥ ENQ_WIDTH
- ENQ_WIDTH, 2, enqueue lanes per cycle
- DEQ_WIDTH, 4, head window width (router SRC_COUNT)
- DES_COUNT, 4, destinations per request (router DES_COUNT)
- PAYLOAD_W, 64, opaque payload bits per entry
- clk  in  1  clock
- rst  in  1  reset: one clock, synchronous, active-high
- flush_i  in  1  discard all entries
- enq_vld_i  in  [ENQ_WIDTH]  per-lane request valid
- enq_des_en_i  in  [ENQ_WIDTH][DES_COUNT]  destinations the request may use
- enq_payload_i  in  [ENQ_WIDTH][PAYLOAD_W]  request payload
- enq_rdy_o  out  1  all valid lanes accepted this cycle
- head_vld_o  out  [DEQ_WIDTH]  slot i holds the i-th oldest entry; drives router src_vld_i
- head_des_en_o  out  [DEQ_WIDTH][DES_COUNT]  drives router src_des_en_i
- head_payload_o  out  [DEQ_WIDTH][PAYLOAD_W]  payload of the head slots
- deq_success_i  in  [DEQ_WIDTH]  router success_o
- count_o  out  $clog2(ENTRY_COUNT+1)  occupied entries

## Operation
- State: head_ptr, tail_ptr ($clog2(ENTRY_COUNT) bits, wrap modulo ENTRY_COUNT), count register, entry storage. Storage is not reset.
- enq_rdy_o = !flush_i && (ENTRY_COUNT − count ≥ ENQ_WIDTH). Uses registered count only; same-cycle dequeue does not free space.
- Enqueue fires when enq_rdy_o is high. Valid lanes are compacted in lane order: lane i writes slot tail_ptr + popcount(enq_vld_i[i−1:0]). enq_n = popcount(enq_vld_i). Lanes may be non-contiguous. Invalid lanes write nothing.
- Head window: head_vld_o[i] = (i < count). Slot i shows storage[head_ptr + i]. head_des_en_o is masked to 0 where head_vld_o[i] is 0. head_payload_o is undefined where head_vld_o[i] is 0.
- Dequeue: deq_n = number of leading ones of (deq_success_i & head_vld_o), counted from bit 0. Bits after the first zero are ignored.
- Update: head_ptr += deq_n; tail_ptr += enq_n (only if enqueue fires); count += enq_n − deq_n.
- A simultaneous enqueue and dequeue is always legal. Count cannot underflow or overflow because of the rdy rule and the head_vld mask.
- Flush: head_ptr, tail_ptr and count go to 0 next cycle. Flush overrides enqueue and dequeue in the same cycle, and enq_rdy_o is low during the flush cycle.
- Reset: identical to flush. Reset may arrive mid-operation; in-flight entries are dropped.

## Timing
- Reset values: count_o = 0, head_vld_o = 0, head_des_en_o = 0, enq_rdy_o = 1 (deasserted while flush_i is high).
- Enqueue-to-head latency is 1 cycle. There is no bypass: an entry written in cycle N appears on head_vld_o in cycle N+1 at the earliest.
- The dequeue loop is combinational: head outputs → router → deq_success_i → pointer update in the same cycle. head_* outputs depend only on registers, so there is no combinational loop.
- Full: with count > ENTRY_COUNT − ENQ_WIDTH, enq_rdy_o is low even if the same cycle dequeues.
- Empty: head_vld_o = 0, and deq_success_i is ignored.
- Wrap-around: pointers wrap silently. The head window may straddle the end of the storage array.

## Structure
- No package types are needed; parameters are local. The payload is opaque.
- Sub-module prefix_ones_count (parameter WIDTH): input vector, output = number of leading ones from bit 0, width $clog2(WIDTH+1). Used for deq_n.
- Enqueue lane offsets: in-module popcount loop.
- Storage: flat register array indexed by wrapped pointers.

## Test plan
- Reset, then enqueue lanes {1,1} twice → next cycle count_o = 4, head_vld_o = 4'b1111, slots in lane order.
- count = 4, deq_success_i = 4'b1011 → deq_n = 2; next cycle count_o = 2, and the old slot 2 now appears at slot 0.
- count = 7 with ENTRY_COUNT = 8, enq_vld = 2'b01 → enq_rdy_o = 0, no write. After deq_n = 1 → enq_rdy_o = 1 next cycle.
- enq_vld = 2'b10 with tail_ptr = 7 → the entry lands in storage 7. Then fill across the wrap and dequeue the window straddling 7→0; order is preserved.
- count = 5, simultaneous enqueue of 2 and deq_success = 4'b0111 → count_o = 4 next cycle, FIFO order intact.
- flush_i in the same cycle as enqueue and dequeue → count_o = 0 and head_vld_o = 0 next cycle, enqueue dropped. Repeat with rst asserted mid-stream → same result.

Source files
------------

// File: rtl/l1d_inorder_issue_buffer_pkg.sv
// Shared default geometry for the L1D in-order issue buffer.
package l1d_inorder_issue_buffer_pkg;

  localparam int unsigned IIB_ENTRY_COUNT = 8;
  localparam int unsigned IIB_ENQ_WIDTH   = 2;
  localparam int unsigned IIB_DEQ_WIDTH   = 4;
  localparam int unsigned IIB_DES_COUNT   = 4;
  localparam int unsigned IIB_PAYLOAD_W   = 64;

endpackage

// File: rtl/l1d_inorder_issue_buffer_prefix_ones_count.sv
// Counts the run of consecutive ones starting at bit 0 of vec_i.
module prefix_ones_count #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]           vec_i,
  output logic [$clog2(WIDTH+1)-1:0] count_o
);

  localparam int unsigned OUT_W = $clog2(WIDTH + 1);

  logic run_open;

  always_comb begin
    count_o  = '0;
    run_open = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (run_open && vec_i[i]) begin
        count_o = count_o + OUT_W'(1);
      end else begin
        run_open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/l1d_inorder_issue_buffer.sv
// Circular in-order request buffer feeding the L1D router; the oldest
// DEQ_WIDTH entries form the router source vector and its success prefix retires them.
module l1d_inorder_issue_buffer
  import l1d_inorder_issue_buffer_pkg::*;
#(
  parameter int unsigned ENTRY_COUNT = IIB_ENTRY_COUNT,
  parameter int unsigned ENQ_WIDTH   = IIB_ENQ_WIDTH,
  parameter int unsigned DEQ_WIDTH   = IIB_DEQ_WIDTH,
  parameter int unsigned DES_COUNT   = IIB_DES_COUNT,
  parameter int unsigned PAYLOAD_W   = IIB_PAYLOAD_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush_i,
  input  logic [ENQ_WIDTH-1:0]                 enq_vld_i,
  input  logic [ENQ_WIDTH-1:0][DES_COUNT-1:0]  enq_des_en_i,
  input  logic [ENQ_WIDTH-1:0][PAYLOAD_W-1:0]  enq_payload_i,
  output logic                                 enq_rdy_o,
  output logic [DEQ_WIDTH-1:0]                 head_vld_o,
  output logic [DEQ_WIDTH-1:0][DES_COUNT-1:0]  head_des_en_o,
  output logic [DEQ_WIDTH-1:0][PAYLOAD_W-1:0]  head_payload_o,
  input  logic [DEQ_WIDTH-1:0]                 deq_success_i,
  output logic [$clog2(ENTRY_COUNT+1)-1:0]     count_o
);

  localparam int unsigned PTR_W   = $clog2(ENTRY_COUNT);
  localparam int unsigned CNT_W   = $clog2(ENTRY_COUNT + 1);
  localparam int unsigned ENQ_N_W = $clog2(ENQ_WIDTH + 1);
  localparam int unsigned DEQ_N_W = $clog2(DEQ_WIDTH + 1);

  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DES_COUNT-1:0] des_q [ENTRY_COUNT];
  logic [PAYLOAD_W-1:0] pay_q [ENTRY_COUNT];

  logic [ENQ_N_W-1:0]   enq_off [ENQ_WIDTH];
  logic [ENQ_N_W-1:0]   enq_n;
  logic [DEQ_N_W-1:0]   deq_n;
  logic [PTR_W-1:0]     head_idx [DEQ_WIDTH];
  logic                 enq_fire;

  // Ready looks only at registered occupancy; a same-cycle retire frees nothing.
  assign enq_rdy_o = !flush_i && ((CNT_W'(ENTRY_COUNT) - count_q) >= CNT_W'(ENQ_WIDTH));
  assign enq_fire  = enq_rdy_o && !rst;
  assign count_o   = count_q;

  // Compact valid lanes in lane order behind the tail.
  always_comb begin
    enq_n = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      enq_off[i] = enq_n;
      if (enq_vld_i[i]) begin
        enq_n = enq_n + ENQ_N_W'(1);
      end
    end
  end

  always_comb begin
    head_vld_o     = '0;
    head_des_en_o  = '0;
    head_payload_o = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      head_idx[i]       = head_q + PTR_W'(i);
      head_vld_o[i]     = CNT_W'(i) < count_q;
      head_des_en_o[i]  = head_vld_o[i] ? des_q[head_idx[i]] : '0;
      head_payload_o[i] = pay_q[head_idx[i]];
    end
  end

  prefix_ones_count #(
    .WIDTH (DEQ_WIDTH)
  ) u_deq_prefix (
    .vec_i   (deq_success_i & head_vld_o),
    .count_o (deq_n)
  );

  always_comb begin
    head_d  = head_q + PTR_W'(deq_n);
    tail_d  = tail_q;
    count_d = count_q - CNT_W'(deq_n);
    if (enq_fire) begin
      tail_d  = tail_q + PTR_W'(enq_n);
      count_d = count_d + CNT_W'(enq_n);
    end
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (enq_vld_i[i]) begin
          des_q[tail_q + PTR_W'(enq_off[i])] <= enq_des_en_i[i];
          pay_q[tail_q + PTR_W'(enq_off[i])] <= enq_payload_i[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_l1d_inorder_issue_buffer.sv
// Scoreboard bench for l1d_inorder_issue_buffer: directed vectors push expected
// entries, a monitor checks the head window and pops retired entries.
module tb_l1d_inorder_issue_buffer;

  typedef struct {
    logic [63:0] pay;
    logic [3:0]  des;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic [1:0]       enq_vld_i;
  logic [1:0][3:0]  enq_des_en_i;
  logic [1:0][63:0] enq_payload_i;
  logic             enq_rdy_o;
  logic [3:0]       head_vld_o;
  logic [3:0][3:0]  head_des_en_o;
  logic [3:0][63:0] head_payload_o;
  logic [3:0]       deq_success_i;
  logic [3:0]       count_o;

  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   seq    = 1;

  l1d_inorder_issue_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .enq_vld_i      (enq_vld_i),
    .enq_des_en_i   (enq_des_en_i),
    .enq_payload_i  (enq_payload_i),
    .enq_rdy_o      (enq_rdy_o),
    .head_vld_o     (head_vld_o),
    .head_des_en_o  (head_des_en_o),
    .head_payload_o (head_payload_o),
    .deq_success_i  (deq_success_i),
    .count_o        (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One directed cycle: drive inputs, check hand-computed state mid-cycle, record accepted lanes.
  task automatic cycle(input logic r, input logic f, input logic [1:0] v, input logic [3:0] s,
                       input int exp_cnt, input logic exp_rdy);
    int   k;
    ent_t e;
    k = seq;
    rst = r;
    flush_i = f;
    enq_vld_i = v;
    deq_success_i = s;
    for (int l = 0; l < 2; l++) begin
      if (v[l]) begin
        enq_payload_i[l] = 64'hC0DE_0000_0000_0000 | 64'(k);
        enq_des_en_i[l]  = 4'(k) ^ 4'hA;
        k++;
      end else begin
        enq_payload_i[l] = '0;
        enq_des_en_i[l]  = '0;
      end
    end
    @(negedge clk);
    chk("count", 64'(count_o), 64'(exp_cnt));
    chk("head_vld", 64'(head_vld_o), 64'((1 << (exp_cnt > 4 ? 4 : exp_cnt)) - 1));
    chk("enq_rdy", 64'(enq_rdy_o), 64'(exp_rdy));
    if (exp_rdy && !r) begin
      for (int l = 0; l < 2; l++) begin
        if (v[l]) begin
          e.pay = enq_payload_i[l];
          e.des = enq_des_en_i[l];
          exp_q.push_back(e);
        end
      end
    end
    seq = k;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the presented head window with the oldest expected entries.
  initial begin
    int n;
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b1) begin
        exp_q.delete();
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (head_vld_o[i]) begin
            if (i < exp_q.size()) begin
              chk("head_payload", head_payload_o[i], exp_q[i].pay);
              chk("head_des_en", 64'(head_des_en_o[i]), 64'(exp_q[i].des));
            end else begin
              chk("head_vld_extra", 64'(head_vld_o[i]), 64'd0);
            end
          end else begin
            chk("des_mask", 64'(head_des_en_o[i]), 64'd0);
          end
        end
        if (flush_i) begin
          exp_q.delete();
        end else begin
          n = 0;
          for (int i = 0; i < 4; i++) begin
            if (!(head_vld_o[i] && deq_success_i[i])) break;
            n++;
          end
          for (int i = 0; i < n; i++) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    enq_vld_i = '0;
    enq_des_en_i = '0;
    enq_payload_i = '0;
    deq_success_i = '0;
    repeat (2) @(posedge clk);
    #1;
    //     rst  flush vld    succ     cnt rdy
    cycle(1'b0, 1'b0, 2'b00, 4'b0000, 0, 1'b1);
    cycle(1'b0, 1'b0, 2'b11, 4'b0000, 0, 1'b1);
    cycle(1'b0, 1'b0, 2'b11, 4'b0000, 2, 1'b1);
    cycle(1'b0, 1'b0, 2'b00, 4'b1011, 4, 1'b1);
    cycle(1'b0, 1'b0, 2'b00, 4'b0000, 2, 1'b1);
    // Fill to 7 and probe the full boundary.
    cycle(1'b0, 1'b0, 2'b11, 4'b0000, 2, 1'b1);
    cycle(1'b0, 1'b0, 2'b11, 4'b0000, 4, 1'b1);
    cycle(1'b0, 1'b0, 2'b01, 4'b0000, 6, 1'b1);
    cycle(1'b0, 1'b0, 2'b01, 4'b0001, 7, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 4'b0000, 6, 1'b1);
    // Flush with enqueue and dequeue requested, then walk the tail to 7.
    cycle(1'b0, 1'b1, 2'b11, 4'b1111, 6, 1'b0);
    cycle(1'b0, 1'b0, 2'b11, 4'b0000, 0, 1'b1);
    cycle(1'b0, 1'b0, 2'b11, 4'b0000, 2, 1'b1);
    cycle(1'b0, 1'b0, 2'b11, 4'b0000, 4, 1'b1);
    cycle(1'b0, 1'b0, 2'b01, 4'b0000, 6, 1'b1);
    cycle(1'b0, 1'b0, 2'b00, 4'b1111, 7, 1'b0);
    cycle(1'b0, 1'b0, 2'b10, 4'b0000, 3, 1'b1);
    cycle(1'b0, 1'b0, 2'b11, 4'b0001, 4, 1'b1);
    cycle(1'b0, 1'b0, 2'b00, 4'b1111, 5, 1'b1);
    // Simultaneous enqueue and partial dequeue.
    cycle(1'b0, 1'b0, 2'b11, 4'b0000, 1, 1'b1);
    cycle(1'b0, 1'b0, 2'b11, 4'b0000, 3, 1'b1);
    cycle(1'b0, 1'b0, 2'b11, 4'b0111, 5, 1'b1);
    cycle(1'b0, 1'b0, 2'b00, 4'b0000, 4, 1'b1);
    cycle(1'b0, 1'b1, 2'b11, 4'b1111, 4, 1'b0);
    // Reset mid-stream drops in-flight entries.
    cycle(1'b0, 1'b0, 2'b11, 4'b0000, 0, 1'b1);
    cycle(1'b0, 1'b0, 2'b11, 4'b0000, 2, 1'b1);
    cycle(1'b1, 1'b0, 2'b11, 4'b1111, 4, 1'b1);
    cycle(1'b0, 1'b0, 2'b00, 4'b1111, 0, 1'b1);
    cycle(1'b0, 1'b0, 2'b11, 4'b0000, 0, 1'b1);
    cycle(1'b0, 1'b0, 2'b00, 4'b1111, 2, 1'b1);
    cycle(1'b0, 1'b0, 2'b00, 4'b0000, 0, 1'b1);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
